// File: rtl/multicycle_control_fsm_if.sv
// rtl/multicycle_control_fsm_if.sv - opcode/memory handshake and datapath control bundle for the multi-cycle sequencer
interface multicycle_control_fsm_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_src;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [3:0] state_o;
    logic       bus_error;
    logic       illegal_op;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, pc_src, ir_write, i_or_d, mem_read, mem_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               state_o, bus_error, illegal_op
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, pc_src, ir_write, i_or_d, mem_read, mem_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               state_o, bus_error, illegal_op
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - Moore multi-cycle instruction sequencer; ILLEGAL_OP_TRAP_EN enables the sticky unknown-opcode trap
module multicycle_control_fsm #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    multicycle_control_fsm_if.master bus
);
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b000100;
    localparam logic [5:0] OP_SW   = 6'b000101;
    localparam logic [5:0] OP_BEQ  = 6'b000110;
    localparam logic [5:0] OP_ADDI = 6'b000111;
    localparam logic [5:0] OP_SLTI = 6'b000001;

`ifdef ILLEGAL_OP_TRAP_EN
    typedef enum logic [3:0] {
        IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, EXEC_R = 4'd3, WB_R = 4'd4,
        EXEC_I = 4'd5, WB_I = 4'd6, MEM_ADDR = 4'd7, MEM_RD = 4'd8, MEM_WR = 4'd9,
        WB_MEM = 4'd10, BRANCH = 4'd11, ERROR = 4'd12, TRAP = 4'd13
    } state_t;
`else
    typedef enum logic [3:0] {
        IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, EXEC_R = 4'd3, WB_R = 4'd4,
        EXEC_I = 4'd5, WB_I = 4'd6, MEM_ADDR = 4'd7, MEM_RD = 4'd8, MEM_WR = 4'd9,
        WB_MEM = 4'd10, BRANCH = 4'd11, ERROR = 4'd12
    } state_t;
`endif

    typedef struct packed {
        logic       fetchGate;
        logic       pcWriteCond;
        logic       pcSrc;
        logic       iOrD;
        logic       memRead;
        logic       memWrite;
        logic       memToReg;
        logic       regDst;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [2:0] aluOp;
    } ctrl_t;

    state_t           state;
    state_t           nextState;
    ctrl_t            ctrl;
    logic [CNT_W-1:0] waitCnt;
    logic [CNT_W-1:0] nextCnt;
    logic             inWait;
    logic             timeoutHit;
    logic             enteringWait;
    logic             busError;

    // Control word for a state; registering it against nextState keeps outputs aligned with state.
    function automatic ctrl_t decodeState(state_t st, logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (st)
            FETCH:    begin c.fetchGate = 1'b1; c.memRead = 1'b1; c.aluSrcB = 2'b01; c.aluOp = 3'b011; end
            DECODE:   begin c.aluSrcB = 2'b11; c.aluOp = 3'b011; end
            EXEC_R:   begin c.aluSrcA = 1'b1; end
            WB_R:     begin c.regDst = 1'b1; c.regWrite = 1'b1; end
            EXEC_I:   begin
                c.aluSrcA = 1'b1;
                c.aluSrcB = 2'b10;
                c.aluOp   = (op == OP_SLTI) ? 3'b010 : 3'b011;
            end
            WB_I:     begin c.regWrite = 1'b1; end
            MEM_ADDR: begin c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; c.aluOp = 3'b011; end
            MEM_RD:   begin c.memRead = 1'b1; c.iOrD = 1'b1; end
            MEM_WR:   begin c.memWrite = 1'b1; c.iOrD = 1'b1; end
            WB_MEM:   begin c.memToReg = 1'b1; c.regWrite = 1'b1; end
            BRANCH:   begin c.aluSrcA = 1'b1; c.aluOp = 3'b001; c.pcWriteCond = 1'b1; c.pcSrc = 1'b1; end
            default:  ;
        endcase
        return c;
    endfunction

    always_comb begin
        inWait     = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
        timeoutHit = inWait && !bus.mem_ready && (MEM_TIMEOUT != 0) &&
                     (waitCnt == CNT_W'(MEM_TIMEOUT));
        nextState  = IDLE;
        case (state)
            IDLE:     nextState = FETCH;
            FETCH:    nextState = bus.mem_ready ? DECODE : (timeoutHit ? ERROR : FETCH);
            DECODE: begin
                case (bus.opcode)
                    OP_R:             nextState = EXEC_R;
                    OP_LW, OP_SW:     nextState = MEM_ADDR;
                    OP_ADDI, OP_SLTI: nextState = EXEC_I;
                    OP_BEQ:           nextState = BRANCH;
`ifdef ILLEGAL_OP_TRAP_EN
                    default:          nextState = TRAP;
`else
                    default:          nextState = FETCH;
`endif
                endcase
            end
            EXEC_R:   nextState = WB_R;
            WB_R:     nextState = FETCH;
            EXEC_I:   nextState = WB_I;
            WB_I:     nextState = FETCH;
            MEM_ADDR: nextState = (bus.opcode == OP_SW) ? MEM_WR : MEM_RD;
            MEM_RD:   nextState = bus.mem_ready ? WB_MEM : (timeoutHit ? ERROR : MEM_RD);
            MEM_WR:   nextState = bus.mem_ready ? FETCH : (timeoutHit ? ERROR : MEM_WR);
            WB_MEM:   nextState = FETCH;
            BRANCH:   nextState = FETCH;
            ERROR:    nextState = ERROR;
`ifdef ILLEGAL_OP_TRAP_EN
            TRAP:     nextState = TRAP;
`endif
            default:  nextState = IDLE;
        endcase

        // Each memory wait state gets a fresh budget on entry.
        enteringWait = ((nextState == FETCH) || (nextState == MEM_RD) || (nextState == MEM_WR)) &&
                       (nextState != state);
        nextCnt = waitCnt;
        if (enteringWait) begin
            nextCnt = '0;
        end else if (inWait && !bus.mem_ready) begin
            nextCnt = waitCnt + CNT_W'(1);
        end
    end

`ifdef ILLEGAL_OP_TRAP_EN
    logic illegalOp;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ctrl      <= '0;
            waitCnt   <= '0;
            busError  <= 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
            illegalOp <= 1'b0;
`endif
        end else begin
            state   <= nextState;
            ctrl    <= decodeState(nextState, bus.opcode);
            waitCnt <= nextCnt;
            if (nextState == ERROR) begin
                busError <= 1'b1;
            end
`ifdef ILLEGAL_OP_TRAP_EN
            if (nextState == TRAP) begin
                illegalOp <= 1'b1;
            end
`endif
        end
    end

    // The only Mealy terms: the fetch completes in the same cycle memory answers.
    assign bus.pc_write      = ctrl.fetchGate & bus.mem_ready;
    assign bus.ir_write      = ctrl.fetchGate & bus.mem_ready;
    assign bus.pc_write_cond = ctrl.pcWriteCond;
    assign bus.pc_src        = ctrl.pcSrc;
    assign bus.i_or_d        = ctrl.iOrD;
    assign bus.mem_read      = ctrl.memRead;
    assign bus.mem_write     = ctrl.memWrite;
    assign bus.mem_to_reg    = ctrl.memToReg;
    assign bus.reg_dst       = ctrl.regDst;
    assign bus.reg_write     = ctrl.regWrite;
    assign bus.alu_src_a     = ctrl.aluSrcA;
    assign bus.alu_src_b     = ctrl.aluSrcB;
    assign bus.alu_op        = ctrl.aluOp;
    assign bus.state_o       = state;
    assign bus.bus_error     = busError;
`ifdef ILLEGAL_OP_TRAP_EN
    assign bus.illegal_op    = illegalOp;
`else
    assign bus.illegal_op    = 1'b0;
`endif
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - scoreboard bench for multicycle_control_fsm
module tb_multicycle_control_fsm;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   evBase = 0;
    bit   monEn = 1'b0;
    int   nChecks = 0;
    int   nPass = 0;

    typedef struct packed {
        int          k;
        logic [15:0] sig;
    } ev_t;

    ev_t        expQ[$];
    logic       mrSched[$];
    logic [5:0] opSched[$];
    logic [15:0] monSig;
    ev_t         monEv;

    multicycle_control_fsm_if bus();

    multicycle_control_fsm #(.MEM_TIMEOUT(15), .CNT_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [15:0] mkSig(bit irw, bit pwc, bit pcs, bit iod, bit mr, bit mw,
                                          bit m2r, bit rd, bit rw, bit a, logic [1:0] b, logic [2:0] op);
        return {irw, irw, pwc, pcs, iod, mr, mw, m2r, rd, rw, a, b, op};
    endfunction

    function automatic logic [17:0] outVec();
        return {bus.pc_write, bus.pc_write_cond, bus.pc_src, bus.ir_write, bus.i_or_d, bus.mem_read,
                bus.mem_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
                bus.alu_src_b, bus.alu_op, bus.bus_error, bus.illegal_op};
    endfunction

    function automatic logic [5:0] strobes();
        return {bus.pc_write, bus.pc_write_cond, bus.ir_write, bus.mem_read, bus.mem_write, bus.reg_write};
    endfunction

    function automatic bit isLegal(logic [5:0] op);
        return op inside {6'b000000, 6'b000100, 6'b000101, 6'b000110, 6'b000111, 6'b000001};
    endfunction

    task automatic pushEv(input int k, input logic [15:0] s);
        ev_t e;
        e.k = k;
        e.sig = s;
        expQ.push_back(e);
    endtask

    // Reference model: per-instruction list of visible control cycles plus the mem_ready schedule.
    task automatic addInstr(input logic [5:0] op, input int wf, input int wm);
        int  b;
        int  len;
        bit  isMem;
        logic r;
        b = mrSched.size();
        isMem = 1'b0;
        pushEv(b + wf, mkSig(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b01, 3'b011));
        case (op)
            6'b000000: begin
                pushEv(b + wf + 2, mkSig(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b000));
                pushEv(b + wf + 3, mkSig(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 3'b000));
                len = wf + 4;
            end
            6'b000111, 6'b000001: begin
                pushEv(b + wf + 2, mkSig(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10,
                                         (op == 6'b000001) ? 3'b010 : 3'b011));
                pushEv(b + wf + 3, mkSig(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 3'b000));
                len = wf + 4;
            end
            6'b000100: begin
                pushEv(b + wf + 2, mkSig(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b011));
                for (int j = 0; j <= wm; j++)
                    pushEv(b + wf + 3 + j, mkSig(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 3'b000));
                pushEv(b + wf + 4 + wm, mkSig(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 3'b000));
                len = wf + 5 + wm;
                isMem = 1'b1;
            end
            6'b000101: begin
                pushEv(b + wf + 2, mkSig(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b011));
                for (int j = 0; j <= wm; j++)
                    pushEv(b + wf + 3 + j, mkSig(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 3'b000));
                len = wf + 4 + wm;
                isMem = 1'b1;
            end
            6'b000110: begin
                pushEv(b + wf + 2, mkSig(0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b001));
                len = wf + 3;
            end
            default: len = wf + 2;
        endcase
        for (int k = 0; k < len; k++) begin
            r = 1'($urandom_range(0, 1));
            if (k < wf) r = 1'b0;
            else if (k == wf) r = 1'b1;
            else if (isMem && k >= wf + 3 && k < wf + 3 + wm) r = 1'b0;
            else if (isMem && k == wf + 3 + wm) r = 1'b1;
            mrSched.push_back(r);
            opSched.push_back(op);
        end
    endtask

    function automatic int pickWait();
        int r;
        r = int'($urandom_range(0, 11));
        return (r < 10) ? (r % 4) : 15;
    endfunction

    function automatic logic [5:0] pickOp();
        logic [5:0] legal [6];
        logic [5:0] op;
        legal = '{6'b000000, 6'b000100, 6'b000101, 6'b000110, 6'b000111, 6'b000001};
`ifndef ILLEGAL_OP_TRAP_EN
        if ($urandom_range(0, 7) == 0) begin
            op = 6'($urandom);
            while (isLegal(op)) op = 6'($urandom);
            return op;
        end
`endif
        op = legal[$urandom_range(0, 5)];
        return op;
    endfunction

    always @(negedge clk) begin
        if (monEn && !rst) begin
            check("rd_wr_exclusive", {31'd0, bus.mem_read & bus.mem_write}, 32'd0);
            monSig = {bus.ir_write, bus.pc_write, bus.pc_write_cond, bus.pc_src, bus.i_or_d, bus.mem_read,
                      bus.mem_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
                      bus.alu_src_b, bus.alu_op};
            if (bus.ir_write | bus.reg_write | bus.mem_write | (bus.mem_read & bus.i_or_d) |
                bus.pc_write_cond | bus.alu_src_a) begin
                if (expQ.size() == 0) begin
                    nChecks++;
                    $display("FAIL unexpected_event: cycle %0d sig 0x%0h, none expected", cyc - evBase, monSig);
                end else begin
                    monEv = expQ.pop_front();
                    check("event_cycle", 32'(cyc - evBase), 32'(monEv.k));
                    check("event_sig", {16'd0, monSig}, {16'd0, monEv.sig});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.opcode = 6'd0;
        bus.mem_ready = 1'b0;

        addInstr(6'b000000, 0, 0);
        addInstr(6'b000100, 0, 3);
        addInstr(6'b000110, 1, 0);
        addInstr(6'b000001, 0, 0);
        addInstr(6'b000111, 2, 0);
        addInstr(6'b000101, 0, 0);
`ifndef ILLEGAL_OP_TRAP_EN
        addInstr(6'b111111, 0, 0);
`endif
        addInstr(6'b000100, 15, 15);
        addInstr(6'b000101, 1, 15);
        for (int i = 0; i < 40; i++) addInstr(pickOp(), pickWait(), pickWait());

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", {28'd0, bus.state_o}, 32'd0);
        check("reset_outputs", {14'd0, outVec()}, 32'd0);

        @(posedge clk); #1;
        rst = 1'b0;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        check("idle_state", {28'd0, bus.state_o}, 32'd0);
        check("idle_outputs", {14'd0, outVec()}, 32'd0);

        @(posedge clk); #1;
        evBase = cyc;
        monEn = 1'b1;
        for (int k = 0; k < mrSched.size(); k++) begin
            bus.mem_ready = mrSched[k];
            bus.opcode = opSched[k];
            if (k == 0) begin
                @(negedge clk);
                check("fetch_mem_read", {31'd0, bus.mem_read}, 32'd1);
                check("fetch_src_b", {30'd0, bus.alu_src_b}, 32'd1);
            end
            @(posedge clk); #1;
        end
        check("queue_drained", expQ.size(), 32'd0);

        // Fetch never answered: 15 waits tolerated, error on the next stalled cycle.
        bus.opcode = 6'b000000;
        bus.mem_ready = 1'b0;
        repeat (15) begin @(posedge clk); #1; end
        @(negedge clk);
        check("timeout_edge_no_error", {31'd0, bus.bus_error}, 32'd0);
        check("timeout_edge_fetching", {31'd0, bus.mem_read}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("bus_error_set", {31'd0, bus.bus_error}, 32'd1);
        check("error_strobes", {26'd0, strobes()}, 32'd0);
        bus.mem_ready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("bus_error_sticky", {31'd0, bus.bus_error}, 32'd1);
        check("error_strobes_held", {26'd0, strobes()}, 32'd0);

        monEn = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("async_reset_outputs", {14'd0, outVec()}, 32'd0);
        check("async_reset_state", {28'd0, bus.state_o}, 32'd0);

        @(posedge clk); #1;
        rst = 1'b0;
        bus.opcode = 6'b000101;
        bus.mem_ready = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        bus.mem_ready = 1'b0;
        @(negedge clk);
        check("sw_mem_write", {31'd0, bus.mem_write}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_instr_reset_strobes", {26'd0, strobes()}, 32'd0);
        check("mid_instr_reset_state", {28'd0, bus.state_o}, 32'd0);

`ifdef ILLEGAL_OP_TRAP_EN
        @(posedge clk); #1;
        rst = 1'b0;
        bus.opcode = 6'b111111;
        bus.mem_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        check("illegal_op_set", {31'd0, bus.illegal_op}, 32'd1);
        check("trap_strobes", {26'd0, strobes()}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("illegal_op_sticky", {31'd0, bus.illegal_op}, 32'd1);
        check("trap_strobes_held", {26'd0, strobes()}, 32'd0);
`else
        check("illegal_op_tied", {31'd0, bus.illegal_op}, 32'd0);
`endif

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
